// File: rtl/uart_retrans_rx.sv
// uart_retrans_rx
//   Single-clock UART frame receiver. One serial bit is sampled per clock.
//   Frame (LSB first): start(0), DATA_BITS data bits, even parity bit, stop(1).
//   A good frame raises `valid` until `ack`. A bad frame (parity or stop-bit
//   failure) raises `error` for TIMEOUT cycles, then issues a one-cycle
//   `request_resend` and bumps the saturating `resend_count`.
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   signal         serial line, idle high
//   ack            consumer acknowledge of a held valid frame
//   error          bad frame detected (also high during the resend cycle)
//   resend_count   number of resend requests since last ack/reset
//   request_resend one-cycle retransmission request
//   valid          good frame held, awaiting ack
module uart_retrans_rx #(
  parameter int DATA_BITS = 7,
  parameter int TIMEOUT   = 8,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal,
  input  logic             ack,
  output logic             error,
  output logic [CNT_W-1:0] resend_count,
  output logic             request_resend,
  output logic             valid
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PARITY, S_STOP, S_VALID, S_ERROR, S_RESEND
  } state_t;

  state_t           state, state_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [TW-1:0]    to_cnt, to_cnt_n;
  logic             par_acc, par_acc_n;
  logic             par_ok, par_ok_n;
  logic [CNT_W-1:0] rcnt_n;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    to_cnt_n  = to_cnt;
    par_acc_n = par_acc;
    par_ok_n  = par_ok;
    rcnt_n    = resend_count;
    unique case (state)
      S_IDLE: begin
        if (!signal) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
          par_acc_n = 1'b0;
        end
      end
      S_DATA: begin
        par_acc_n = par_acc ^ signal;
        bit_cnt_n = bit_cnt + BW'(1);
        if (bit_cnt == LAST_BIT) state_n = S_PARITY;
      end
      S_PARITY: begin
        par_ok_n = ~(par_acc ^ signal);
        state_n  = S_STOP;
      end
      S_STOP: begin
        // A break (stop = 0) is an error even when parity checks out.
        to_cnt_n = '0;
        state_n  = (signal && par_ok) ? S_VALID : S_ERROR;
      end
      S_VALID: begin
        if (ack) begin
          state_n = S_IDLE;
          rcnt_n  = '0;
        end
      end
      S_ERROR: begin
        to_cnt_n = to_cnt + TW'(1);
        if (to_cnt == TO_LAST) begin
          state_n = S_RESEND;
          // Count lands together with the request pulse.
          if (resend_count != CNT_MAX) rcnt_n = resend_count + CNT_W'(1);
        end
      end
      S_RESEND: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      par_acc        <= 1'b0;
      par_ok         <= 1'b0;
      resend_count   <= '0;
      valid          <= 1'b0;
      error          <= 1'b0;
      request_resend <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      to_cnt         <= to_cnt_n;
      par_acc        <= par_acc_n;
      par_ok         <= par_ok_n;
      resend_count   <= rcnt_n;
      valid          <= (state_n == S_VALID);
      error          <= (state_n == S_ERROR) || (state_n == S_RESEND);
      request_resend <= (state_n == S_RESEND);
    end
  end

endmodule

// File: tb/tb_uart_retrans_rx.sv
// Directed bench for uart_retrans_rx (DATA_BITS=7, TIMEOUT=8, CNT_W=5).
// Inputs change after a rising edge; outputs are sampled 1 time unit after
// the edge, so each observation reflects the edge just taken.
module tb_uart_retrans_rx;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       signal = 1'b1;
  logic       ack = 1'b0;
  logic       error, request_resend, valid;
  logic [4:0] resend_count;

  int total = 0;
  int bad   = 0;

  uart_retrans_rx #(.DATA_BITS(7), .TIMEOUT(8), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .signal(signal), .ack(ack),
    .error(error), .resend_count(resend_count),
    .request_resend(request_resend), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e, input logic r,
                         input logic v, input logic [4:0] c);
    chk({tag, ".error"}, {31'b0, error}, {31'b0, e});
    chk({tag, ".req"},   {31'b0, request_resend}, {31'b0, r});
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
    chk({tag, ".cnt"},   {27'b0, resend_count}, {27'b0, c});
  endtask

  task automatic do_reset();
    reset = 1'b0; signal = 1'b1; ack = 1'b0;
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 5'd0);
    reset = 1'b1;
  endtask

  // Sends start..stop; d[0] goes first. Flags must stay low until the stop edge.
  task automatic send_frame(input logic [6:0] d, input logic par, input logic stp);
    signal = 1'b0;
    tick();
    chk({31'b0, valid | error} == 0 ? "start" : "start", {31'b0, valid | error}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      signal = d[i];
      tick();
      chk("data.flags", {31'b0, valid | error | request_resend}, 32'd0);
    end
    signal = par;
    tick();
    chk("par.flags", {31'b0, valid | error}, 32'd0);
    signal = stp;
    tick();
    signal = 1'b1;
  endtask

  // Called right after the stop edge E of a bad frame.
  task automatic bad_tail(input logic [4:0] prev, input logic [4:0] exp, input bit poke);
    chk_all("err.E", 1'b1, 1'b0, 1'b0, prev);
    for (int i = 1; i < 8; i++) begin
      ack = poke ? logic'(i % 2) : 1'b0;
      tick();
      chk_all("err.hold", 1'b1, 1'b0, 1'b0, prev);
    end
    ack = 1'b0;
    tick();
    chk_all("resend", 1'b1, 1'b1, 1'b0, exp);
    tick();
    chk_all("after", 1'b0, 1'b0, 1'b0, exp);
  endtask

  initial begin
    tick();
    chk_all("por", 1'b0, 1'b0, 1'b0, 5'd0);
    do_reset();

    // Good frame, held for three cycles, then acked.
    send_frame(7'b1010101, 1'b0, 1'b1);
    chk_all("good.k10", 1'b0, 1'b0, 1'b1, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("good.hold", 1'b0, 1'b0, 1'b1, 5'd0);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("good.acked", 1'b0, 1'b0, 1'b0, 5'd0);

    // Parity error then timeout.
    send_frame(7'b1010101, 1'b1, 1'b1);
    bad_tail(5'd0, 5'd1, 1'b0);

    // Break: parity fine, stop bit 0.
    do_reset();
    send_frame(7'b0000000, 1'b0, 1'b0);
    bad_tail(5'd0, 5'd1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk_all("break.idle", 1'b0, 1'b0, 1'b0, 5'd1);

    // Retry then success: count visible in VALID, cleared by ack.
    do_reset();
    send_frame(7'b0000000, 1'b1, 1'b1);
    bad_tail(5'd0, 5'd1, 1'b0);
    send_frame(7'b0000111, 1'b1, 1'b1);
    chk_all("retry.valid", 1'b0, 1'b0, 1'b1, 5'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("retry.acked", 1'b0, 1'b0, 1'b0, 5'd0);

    // Reset at data bit 4.
    signal = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      signal = 1'b1;
      tick();
    end
    do_reset();
    // Reset during ERROR: no resend may follow.
    send_frame(7'b1010101, 1'b1, 1'b1);
    chk_all("rst.err", 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst.noreq", {31'b0, request_resend | error}, 32'd0);
    end
    send_frame(7'b0000111, 1'b1, 1'b1);
    chk_all("rst.good", 1'b0, 1'b0, 1'b1, 5'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("rst.acked", 1'b0, 1'b0, 1'b0, 5'd0);

    // 33 back-to-back bad frames with ack pokes in ERROR: saturates at 31.
    do_reset();
    for (int f = 0; f < 33; f++) begin
      logic [4:0] p, e;
      p = (f >= 31) ? 5'd31 : 5'(f);
      e = (f >= 30) ? 5'd31 : 5'(f + 1);
      send_frame(7'b1100000, 1'b1, 1'b1);
      bad_tail(p, e, 1'b1);
    end
    chk_all("sat.final", 1'b0, 1'b0, 1'b0, 5'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_retrans_rx.md
# uart_retrans_rx

Single-clock UART frame receiver with even-parity checking and timed retransmission requests. It deserialises one bit per clock from `signal`, flags good frames with `valid` until `ack`, and flags bad frames with `error`. After a fixed timeout on a bad frame it pulses `request_resend` and counts the retry in `resend_count`. It sits between the serial line front end and the link-level controller that issues retransmissions.

## Interface
- `DATA_BITS`, default 7: data bits per frame.
- `TIMEOUT`, default 8: clock cycles spent in ERROR before a resend request (≥1).
- `CNT_W`, default 5: width of `resend_count`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `signal`  in  1  serial line, one bit per clock, idle high.
- `ack`  in  1  consumer acknowledge of a valid frame.
- `error`  out  1  bad frame detected (parity or stop-bit failure).
- `resend_count`  out  CNT_W  number of resend requests issued.
- `request_resend`  out  1  one-cycle retransmission request.
- `valid`  out  1  good frame held, awaiting `ack`.

## Operation
- Frame format, LSB first: start (0), DATA_BITS data bits, parity bit, stop (1).
- Even parity: the XOR of the data bits and the parity bit must be 0.
- All outputs are registered and are functions of the state and counters.
- States and transitions:
  - IDLE: `signal`=0 → DATA, bit counter cleared. `signal`=1 stays in IDLE.
  - DATA: shift in DATA_BITS bits and accumulate parity. After the last bit → PARITY.
  - PARITY: sample the parity bit and compute parity_ok → STOP.
  - STOP: if `signal`=1 and parity_ok → VALID; otherwise → ERROR. A stop bit of 0 (break) is an error regardless of parity.
  - VALID: `valid`=1. `ack`=1 → IDLE and `resend_count` cleared to 0. `signal` is ignored in this state.
  - ERROR: `error`=1 and the timeout counter increments. When the counter reaches TIMEOUT → RESEND. `signal` and `ack` are ignored.
  - RESEND: `request_resend`=1 and `error`=1 for exactly one cycle. `resend_count` increments, saturating at 2^CNT_W−1 (31). Next state is IDLE.
- `ack` outside VALID has no effect.
- `resend_count` holds its value in every other state.

## Timing
- Reset (`reset`=0 at a rising edge): state IDLE, all counters cleared, and `error`=0, `valid`=0, `request_resend`=0, `resend_count`=0 from the next cycle.
- Reset mid-frame, in VALID, or in ERROR aborts immediately with the same result.
- Let the start bit be sampled at edge k. Data bits are sampled at k+1..k+7, parity at k+8, stop at k+9.
- `valid` or `error` rises after edge k+9, giving 10 cycles of start-to-flag latency.
- `valid` stays high through the cycle in which `ack` is sampled and falls after that edge.
- For an error at edge E: `error` is high for the cycles after E..E+TIMEOUT−1. `request_resend` and the `resend_count` increment appear after edge E+TIMEOUT. Both `error` and `request_resend` fall after edge E+TIMEOUT+1.
- Back-to-back frames: a new start bit is accepted on the first edge in IDLE, which is the cycle after the `ack` edge or the RESEND cycle.

## Test plan
- Good frame: reset; send 0, data 1,0,1,0,1,0,1 (four ones), parity 0, stop 1; hold `ack`=0 for 3 cycles, then 1 for 1 cycle.
  - `valid`=1 from cycle k+10 until the `ack` edge, then 0.
  - `error`=0, `request_resend`=0, `resend_count`=0 throughout.
- Parity error then timeout: send data 1,0,1,0,1,0,1 with parity 1 and stop 1; wait 10 cycles.
  - `error`=1 for TIMEOUT+1 = 9 cycles.
  - `request_resend` high exactly once for 1 cycle.
  - `resend_count`=1, then back to IDLE with `error`=0.
  - `valid` never asserts.
- Break / no stop bit: data all 0, parity 0, stop 0.
  - `error` asserts at k+10, then `request_resend` pulse.
  - `resend_count` increments to 1 and stays 1 with no further traffic.
- Retry then success: one bad frame, then a good frame of data 1,1,1,0,0,0,0 with parity 1, then `ack`.
  - `resend_count` reads 1 during VALID and 0 after `ack`.
- Reset mid-operation: assert `reset`=0 at data bit 4 and again during ERROR.
  - All outputs are 0 the next cycle and no `request_resend` pulse occurs.
  - A subsequent good frame is received normally.
- Saturation and ignored inputs: 33 consecutive bad frames.
  - `resend_count` saturates at 31.
  - `ack` pulses during ERROR have no effect.
